dual_port_ram_arbiter: RTL and testbench
========================================

Name: dual_port_ram_arbiter

Overview:
- Shares one simple dual-port RAM between NUM_REQ requesters.
- The RAM has one write port and one registered read port with 1-cycle read latency.
- The write port and the read port are arbitrated independently, each round-robin, so one requester's write and another's read can both be granted in the same cycle.
- Sits between client engines and the RAM instance. Read data is routed back as a shared bus plus a per-requester valid strobe.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 12, RAM address width.

Ports:
- clk  in  1  single clock for the arbiter and the RAM.
- reset_n  in  1  asynchronous, active-low reset.
- wr_req  in  NUM_REQ  per-requester write request.
- wr_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses; requester i occupies slice i.
- wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_WIDTH  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant.
- rd_valid  out  NUM_REQ  one-cycle strobe marking return data for requester i.
- rd_data  out  DATA_WIDTH  shared read-return data.
- ram_we  out  1  RAM write enable.
- ram_write_addr  out  ADDR_WIDTH  RAM write address.
- ram_data_in  out  DATA_WIDTH  RAM write data.
- ram_read_addr  out  ADDR_WIDTH  RAM read address.
- ram_data_out  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Handshake:
  - A requester holds req high, with stable addr/data, until it samples gnt=1 at a rising clk edge.
  - The transfer occurs on that edge.
  - Req may drop or re-assert for a new transfer the following cycle.
- Grants are combinational from req and the priority pointer. At most one bit of each gnt vector is high. gnt=0 when no req.
- Round-robin (per port, independent):
  - Each port has a pointer last_w / last_r.
  - The search starts at (last+1) mod NUM_REQ.
  - On each edge with a grant, last <= granted index. With no grant, last holds.
  - Reset value NUM_REQ-1, so requester 0 wins first.
- Write path:
  - ram_we = |wr_gnt.
  - ram_write_addr and ram_data_in are muxed from the granted slice.
  - When there is no grant, both are held at 0.
- Read path:
  - ram_read_addr is muxed from the granted slice, or 0 when no grant.
  - On a grant edge: pend_v <= 1, pend_id <= granted index. Otherwise pend_v <= 0.
  - Cycle t+1 after the grant edge: rd_valid[pend_id] = pend_v, and rd_data = ram_data_out. Total latency 1 cycle.
  - Back-to-back reads every cycle are supported: throughput 1 read/cycle and 1 write/cycle.
- Collision:
  - A write and a read to the same address granted on the same edge return OLD data (read-before-write).
  - A read granted one cycle after the write returns NEW data.
  - No forwarding.
- Reset:
  - While reset_n=0: wr_gnt=0, rd_gnt=0, ram_we=0, rd_valid=0, addresses/data outputs 0.
  - Pointers go to NUM_REQ-1 and pend_v=0.
  - Reset asserted mid-operation discards any pending read. No rd_valid is emitted after release for a read granted before reset.
- Fairness: under continuous requests from all NUM_REQ requesters, each requester is granted exactly once per NUM_REQ consecutive cycles on each port.
- Width rules:
  - The index register width is clog2(NUM_REQ).
  - Slices are selected as [i*W +: W].

Decomposition:
- Shared package/header: clog2 function and index-width constant. No other typedefs.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Inputs: req[N], clk, reset_n.
  - Outputs: one-hot gnt[N] and gnt_idx.
  - Owns its pointer.
  - Instantiated twice, once for the write port and once for the read port.
- The top-level module holds the slice muxes and the pend_v/pend_id pipeline register.

Test Plan:
- Setup for all scenarios: NUM_REQ=2, DATA_WIDTH=8, ADDR_WIDTH=4, with a behavioural RAM attached.
- Reset release, req0 writes 0xA5@3 -> wr_gnt=01 same cycle, ram_we=1, addr 3. Next cycle req1 reads @3 -> rd_gnt=10, then next cycle rd_valid=10, rd_data=0xA5.
- Both requesters hold wr_req for 6 cycles -> wr_gnt sequence 01,10,01,10,01,10; each requester's write lands once per 2 cycles.
- req0 writes 0x3C@7 while req1 reads @7 on the same edge (RAM pre-loaded 0x11) -> rd_data=0x11. A repeat read the next cycle returns 0x3C.
- Continuous reads by both, addresses 0..5 alternating -> rd_valid alternates 01/10 every cycle with no gaps; rd_data matches RAM contents in order.
- reset_n pulled low the cycle after a read grant -> rd_valid never asserts; after release pointers restart with requester 0 winning the first contested grant.
- No requests for 4 cycles -> all gnt=0, ram_we=0, rd_valid=0, pointers unchanged.

Source files
------------

// File: rtl/dual_port_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter_pkg -- shared index-width helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dual_port_ram_arbiter_pkg;

  localparam int MAX_REQ = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

  // A single requester still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dual_port_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter_if -- requester-side write/read handshake bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dual_port_ram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic [NUM_REQ-1:0]            wr_gnt;
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic [NUM_REQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]         rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_gnt, rd_gnt, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_gnt, rd_gnt, rd_valid, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/dual_port_ram_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter -- combinational round-robin grant with registered pointer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int  N     = 2,
  localparam int IDX_W = idx_w(N)
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic [N-1:0]     req,
  output logic      [N-1:0]     gnt,
  output logic      [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Search starts one past the last winner; grants are forced low in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (!found && reset_n && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= IDX_W'(N - 1);
    end else if (found) begin
      last <= gnt_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dual_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dual_port_ram_arbiter -- shares one simple dual-port RAM among NUM_REQ clients. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dual_port_ram_arbiter
  import dual_port_ram_arbiter_pkg::*;
#(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 12,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  dual_port_ram_arbiter_if.slave     bus,
  output logic                       ram_we,
  output logic [ADDR_WIDTH-1:0]      ram_write_addr,
  output logic [DATA_WIDTH-1:0]      ram_data_in,
  output logic [ADDR_WIDTH-1:0]      ram_read_addr,
  input  wire logic [DATA_WIDTH-1:0] ram_data_out
);

  logic [NUM_REQ-1:0] wr_gnt;
  logic [NUM_REQ-1:0] rd_gnt;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               pend_v;
  logic [IDX_W-1:0]   pend_id;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  assign bus.wr_gnt = wr_gnt;
  assign bus.rd_gnt = rd_gnt;
  assign ram_we     = |wr_gnt;

  // Idle ports drive zero rather than the slice of index 0.
  always_comb begin
    ram_write_addr = '0;
    ram_data_in    = '0;
    ram_read_addr  = '0;
    if (|wr_gnt) begin
      ram_write_addr = bus.wr_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_data_in    = bus.wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (|rd_gnt) begin
      ram_read_addr  = bus.rd_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v  <= 1'b0;
      pend_id <= '0;
    end else begin
      pend_v  <= |rd_gnt;
      pend_id <= rd_idx;
    end
  end

  always_comb begin
    bus.rd_valid = '0;
    if (pend_v) begin
      bus.rd_valid[pend_id] = 1'b1;
    end
  end

  assign bus.rd_data = pend_v ? ram_data_out : '0;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram_arbiter -- directed self-checking bench with behavioural RAM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dual_port_ram_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_out;
  logic [DW-1:0] mem [16];

  dual_port_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_data_in    (ram_data_in),
    .ram_read_addr  (ram_read_addr),
    .ram_data_out   (ram_data_out)
  );

  // Registered read port: a same-edge write is not visible to the read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data_in;
    ram_data_out <= mem[ram_read_addr];
  end

  int total = 0;
  int bad   = 0;
  int cnt0;
  int cnt1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_addr[r*AW +: AW] = a;
    bus.wr_data[r*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    bus.rd_addr[r*AW +: AW] = a;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_req = 2'b01;
    set_wr(0, a, d);
    step();
    bus.wr_req = 2'b00;
  endtask

  initial begin
    bus.wr_req  = '0;
    bus.rd_req  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // Requests during reset must not produce grants
    #2;
    bus.wr_req = 2'b11;
    bus.rd_req = 2'b11;
    set_wr(0, 4'd2, 8'h12);
    #1;
    check_val("rst_wr_gnt", 32'(bus.wr_gnt), 0);
    check_val("rst_rd_gnt", 32'(bus.rd_gnt), 0);
    check_val("rst_ram_we", 32'(ram_we), 0);
    check_val("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_val("rst_wr_addr", 32'(ram_write_addr), 0);
    bus.wr_req = '0;
    bus.rd_req = '0;
    step();
    step();
    reset_n = 1'b1;

    // Fairness on the write port
    set_wr(0, 4'd4, 8'h44);
    set_wr(1, 4'd5, 8'h55);
    bus.wr_req = 2'b11;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_val("fair_wr_gnt", 32'(bus.wr_gnt), (c % 2 == 0) ? 1 : 2);
      check_val("fair_wr_addr", 32'(ram_write_addr), (c % 2 == 0) ? 4 : 5);
      step();
    end
    bus.wr_req = '0;
    check_val("fair_mem4", 32'(mem[4]), 32'h44);
    check_val("fair_mem5", 32'(mem[5]), 32'h55);

    // Write then read-back by the other requester
    bus.wr_req = 2'b01;
    set_wr(0, 4'd3, 8'hA5);
    #1;
    check_val("w1_gnt", 32'(bus.wr_gnt), 1);
    check_val("w1_we", 32'(ram_we), 1);
    check_val("w1_addr", 32'(ram_write_addr), 3);
    check_val("w1_data", 32'(ram_data_in), 32'hA5);
    step();
    bus.wr_req = '0;
    bus.rd_req = 2'b10;
    set_rd(1, 4'd3);
    #1;
    check_val("r1_gnt", 32'(bus.rd_gnt), 2);
    check_val("r1_addr", 32'(ram_read_addr), 3);
    step();
    bus.rd_req = '0;
    #1;
    check_val("r1_valid", 32'(bus.rd_valid), 2);
    check_val("r1_data", 32'(bus.rd_data), 32'hA5);

    // Same-edge write/read collision returns old data
    do_write(4'd7, 8'h11);
    bus.wr_req = 2'b01;
    set_wr(0, 4'd7, 8'h3C);
    bus.rd_req = 2'b10;
    set_rd(1, 4'd7);
    #1;
    check_val("col_wr_gnt", 32'(bus.wr_gnt), 1);
    check_val("col_rd_gnt", 32'(bus.rd_gnt), 2);
    step();
    bus.wr_req = '0;
    #1;
    check_val("col_valid_old", 32'(bus.rd_valid), 2);
    check_val("col_data_old", 32'(bus.rd_data), 32'h11);
    step();
    bus.rd_req = '0;
    #1;
    check_val("col_valid_new", 32'(bus.rd_valid), 2);
    check_val("col_data_new", 32'(bus.rd_data), 32'h3C);

    // Back-to-back contested reads of addresses 0..5
    for (int i = 0; i < 6; i++) do_write(AW'(i), DW'(8'hB0 + i));
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        bus.rd_req[0] = (cnt0 < 3);
        bus.rd_req[1] = (cnt1 < 3);
        set_rd(0, AW'(2 * cnt0));
        set_rd(1, AW'(2 * cnt1 + 1));
      end else begin
        bus.rd_req = '0;
      end
      #1;
      if (c < 6) begin
        check_val("b2b_gnt", 32'(bus.rd_gnt), (c % 2 == 0) ? 1 : 2);
        check_val("b2b_addr", 32'(ram_read_addr), c);
      end
      if (c > 0) begin
        check_val("b2b_valid", 32'(bus.rd_valid), ((c - 1) % 2 == 0) ? 1 : 2);
        check_val("b2b_data", 32'(bus.rd_data), 32'hB0 + c - 1);
      end
      step();
      if (c % 2 == 0) cnt0++;
      else cnt1++;
    end

    // Reset right after a read grant drops the pending return
    bus.rd_req = 2'b01;
    set_rd(0, 4'd0);
    #1;
    check_val("mid_rd_gnt", 32'(bus.rd_gnt), 1);
    step();
    reset_n = 1'b0;
    bus.rd_req = '0;
    #1;
    check_val("mid_valid_rst", 32'(bus.rd_valid), 0);
    check_val("mid_data_rst", 32'(bus.rd_data), 0);
    step();
    reset_n = 1'b1;
    #1;
    check_val("mid_valid_rel", 32'(bus.rd_valid), 0);
    step();
    check_val("mid_valid_rel2", 32'(bus.rd_valid), 0);
    bus.wr_req = 2'b11;
    set_wr(0, 4'd8, 8'h80);
    set_wr(1, 4'd9, 8'h90);
    bus.rd_req = 2'b11;
    set_rd(0, 4'd0);
    set_rd(1, 4'd1);
    #1;
    check_val("post_rst_wr_gnt", 32'(bus.wr_gnt), 1);
    check_val("post_rst_rd_gnt", 32'(bus.rd_gnt), 1);
    step();

    // Idle cycles: no grants, pointers hold
    bus.wr_req = '0;
    bus.rd_req = '0;
    #1;
    check_val("idle_first_valid", 32'(bus.rd_valid), 1);
    check_val("idle_first_data", 32'(bus.rd_data), 32'hB0);
    for (int k = 0; k < 4; k++) begin
      check_val("idle_wr_gnt", 32'(bus.wr_gnt), 0);
      check_val("idle_rd_gnt", 32'(bus.rd_gnt), 0);
      check_val("idle_we", 32'(ram_we), 0);
      step();
      check_val("idle_valid", 32'(bus.rd_valid), 0);
    end
    bus.wr_req = 2'b11;
    bus.rd_req = 2'b11;
    #1;
    check_val("hold_wr_gnt", 32'(bus.wr_gnt), 2);
    check_val("hold_rd_gnt", 32'(bus.rd_gnt), 2);
    check_val("hold_wr_addr", 32'(ram_write_addr), 9);
    step();
    bus.wr_req = '0;
    bus.rd_req = '0;
    #1;
    check_val("hold_valid", 32'(bus.rd_valid), 2);
    check_val("hold_data", 32'(bus.rd_data), 32'hB1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
